// File: rtl/seg7_scan_driver_if.sv
// Bundle between the BCD/roll logic and the 7-segment scan driver.
// The master side supplies digits and display controls; the slave side drives the pads.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 2
);
  logic [4*NUM_DIGITS-1:0] data_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic                    seg_pol;
  logic                    com_pol;
  logic                    lz_blank;
  logic                    blink_en;
  logic [7:0]              seg;
  logic [NUM_DIGITS-1:0]   com;
  logic [NUM_DIGITS-1:0]   com_oe;
  logic                    frame_start;
  logic                    pending;

  modport master (
    output data_in, dp_in, load, seg_pol, com_pol, lz_blank, blink_en,
    input  seg, com, com_oe, frame_start, pending
  );

  modport slave (
    input  data_in, dp_in, load, seg_pol, com_pol, lz_blank, blink_en,
    output seg, com, com_oe, frame_start, pending
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with double-buffered digits,
// anti-ghost blanking, leading-zero suppression, blink and runtime pad polarity.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 2,
  parameter int SCAN_DIV     = 1024,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_LOG2   = 22
) (
  input  logic              clk,
  input  logic              rst,
  seg7_scan_driver_if.slave bus
);
  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0] BLANK_END  = SLOT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]  LAST_DIGIT = IDX_W'(NUM_DIGITS - 1);

  logic [SLOT_W-1:0]               slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0]                digit_idx_q, digit_idx_d;
  logic [BLINK_LOG2-1:0]           blink_cnt_q, blink_cnt_d;
  logic [7:0]                      seg_int_q, seg_int_d;
  logic [NUM_DIGITS-1:0]           com_int_q, com_int_d;
  logic                            com_oe_q;
  logic                            frame_start_q, frame_start_d;
  logic [NUM_DIGITS-1:0][3:0]      shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]           shadow_dp_q, shadow_dp_d;
  logic [NUM_DIGITS-1:0][3:0]      staging_q, staging_d;
  logic [NUM_DIGITS-1:0]           staging_dp_q, staging_dp_d;
  logic                            pending_q, pending_d;
  logic                            frame_end;
  logic [NUM_DIGITS-1:0]           lz_mask;
  logic                            lz_run;

  function automatic logic [6:0] decode7(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      4'd15:   p = 7'h00;
      default: p = 7'h40;
    endcase
    return p;
  endfunction

  // Last cycle of the last digit slot: the only point the shadow may change.
  assign frame_end = (slot_cnt_q == LAST_SLOT) && (digit_idx_q == LAST_DIGIT);

  // A digit is suppressed while every digit from it up to the top is zero; digit 0 never is.
  always_comb begin
    lz_mask = '0;
    lz_run  = bus.lz_blank;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lz_run     = lz_run && (shadow_q[i] == 4'd0);
      lz_mask[i] = lz_run;
    end
  end

  always_comb begin
    slot_cnt_d    = (slot_cnt_q == LAST_SLOT) ? '0 : slot_cnt_q + SLOT_W'(1);
    digit_idx_d   = digit_idx_q;
    blink_cnt_d   = blink_cnt_q + BLINK_LOG2'(1);
    frame_start_d = frame_end;
    seg_int_d     = '0;
    com_int_d     = '0;
    shadow_d      = shadow_q;
    shadow_dp_d   = shadow_dp_q;
    staging_d     = staging_q;
    staging_dp_d  = staging_dp_q;
    pending_d     = pending_q;

    if (slot_cnt_q == LAST_SLOT) begin
      digit_idx_d = (digit_idx_q == LAST_DIGIT) ? '0 : digit_idx_q + IDX_W'(1);
    end

    if (slot_cnt_q >= BLANK_END) begin
      if (!lz_mask[digit_idx_q]) begin
        seg_int_d = {shadow_dp_q[digit_idx_q], decode7(shadow_q[digit_idx_q])};
      end
      if (!(bus.blink_en && blink_cnt_q[BLINK_LOG2-1])) begin
        com_int_d[digit_idx_q] = 1'b1;
      end
    end

    // A load landing exactly on the boundary bypasses staging and is shown next frame.
    if (bus.load) begin
      if (frame_end) begin
        shadow_d    = bus.data_in;
        shadow_dp_d = bus.dp_in;
        pending_d   = 1'b0;
      end else begin
        staging_d    = bus.data_in;
        staging_dp_d = bus.dp_in;
        pending_d    = 1'b1;
      end
    end else if (frame_end && pending_q) begin
      shadow_d    = staging_q;
      shadow_dp_d = staging_dp_q;
      pending_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt_q    <= '0;
      digit_idx_q   <= '0;
      blink_cnt_q   <= '0;
      seg_int_q     <= '0;
      com_int_q     <= '0;
      com_oe_q      <= 1'b0;
      frame_start_q <= 1'b0;
      shadow_q      <= '0;
      shadow_dp_q   <= '0;
      staging_q     <= '0;
      staging_dp_q  <= '0;
      pending_q     <= 1'b0;
    end else begin
      slot_cnt_q    <= slot_cnt_d;
      digit_idx_q   <= digit_idx_d;
      blink_cnt_q   <= blink_cnt_d;
      seg_int_q     <= seg_int_d;
      com_int_q     <= com_int_d;
      com_oe_q      <= 1'b1;
      frame_start_q <= frame_start_d;
      shadow_q      <= shadow_d;
      shadow_dp_q   <= shadow_dp_d;
      staging_q     <= staging_d;
      staging_dp_q  <= staging_dp_d;
      pending_q     <= pending_d;
    end
  end

  assign bus.seg         = seg_int_q ^ {8{~bus.seg_pol}};
  assign bus.com         = com_int_q ^ {NUM_DIGITS{~bus.com_pol}};
  assign bus.com_oe      = {NUM_DIGITS{com_oe_q}};
  assign bus.frame_start = frame_start_q;
  assign bus.pending     = pending_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed scenarios plus randomized traffic
// compared every cycle against a cycle-count based model of the display.
module tb_seg7_scan_driver;
  localparam int ND    = 2;
  localparam int SD    = 16;
  localparam int BC    = 2;
  localparam int BL    = 6;
  localparam int FRAME = SD * ND;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_driver #(
    .NUM_DIGITS  (ND),
    .SCAN_DIV    (SD),
    .BLANK_CYCLES(BC),
    .BLINK_LOG2  (BL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [6:0] segTable [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h00};

  // Model state: cyc counts clock edges since reset release; everything else follows from it.
  int                  cyc;
  logic [4*ND-1:0]     mShadow, mStage;
  logic [ND-1:0]       mShadowDp, mStageDp;
  logic                mPending;
  logic [7:0]          expSegInt;
  logic [ND-1:0]       expComInt;
  logic [ND-1:0]       expOe;
  logic                expFs;

  task automatic checkOne(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic checkOutput();
    checkOne("seg", bus.seg, expSegInt ^ {8{~bus.seg_pol}});
    checkOne("com", 8'(bus.com), 8'(expComInt ^ {ND{~bus.com_pol}}));
    checkOne("com_oe", 8'(bus.com_oe), 8'(expOe));
    checkOne("frame_start", 8'(bus.frame_start), 8'(expFs));
    checkOne("pending", 8'(bus.pending), 8'(mPending));
  endtask

  task automatic modelReset();
    cyc       = 0;
    mShadow   = '0;
    mShadowDp = '0;
    mStage    = '0;
    mStageDp  = '0;
    mPending  = 1'b0;
    expSegInt = '0;
    expComInt = '0;
    expOe     = '0;
    expFs     = 1'b0;
  endtask

  // Predicts the outputs after the coming edge from the state and inputs just before it.
  task automatic modelEdge();
    int  slot, digit;
    bit  boundary, lead;
    logic [3:0] nib;
    slot      = cyc % SD;
    digit     = (cyc / SD) % ND;
    boundary  = (cyc % FRAME) == FRAME - 1;
    expSegInt = '0;
    expComInt = '0;
    if (slot >= BC) begin
      nib  = mShadow[digit*4 +: 4];
      lead = bus.lz_blank && (digit != 0);
      for (int j = digit; j < ND; j++) if (mShadow[j*4 +: 4] != 4'd0) lead = 1'b0;
      if (!lead) expSegInt = {mShadowDp[digit], segTable[nib]};
      if (!(bus.blink_en && ((cyc % (1 << BL)) >= (1 << (BL - 1))))) expComInt[digit] = 1'b1;
    end
    expFs = boundary;
    expOe = '1;
    if (bus.load) begin
      if (boundary) begin
        mShadow   = bus.data_in;
        mShadowDp = bus.dp_in;
        mPending  = 1'b0;
      end else begin
        mStage   = bus.data_in;
        mStageDp = bus.dp_in;
        mPending = 1'b1;
      end
    end else if (boundary && mPending) begin
      mShadow   = mStage;
      mShadowDp = mStageDp;
      mPending  = 1'b0;
    end
    cyc++;
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) begin
      modelEdge();
      @(posedge clk);
      #1;
      checkOutput();
    end
  endtask

  task automatic doLoad(input logic [4*ND-1:0] d, input logic [ND-1:0] dp);
    bus.data_in = d;
    bus.dp_in   = dp;
    bus.load    = 1'b1;
    applyStimulus(1);
    bus.load    = 1'b0;
  endtask

  task automatic waitPhase(input int ph);
    while ((cyc % FRAME) != ph) applyStimulus(1);
  endtask

  task automatic crossFrame();
    waitPhase(FRAME - 1);
    applyStimulus(1);
  endtask

  initial begin
    int litCount;
    int fsCount;
    rst          = 1'b1;
    bus.data_in  = '0;
    bus.dp_in    = '0;
    bus.load     = 1'b0;
    bus.seg_pol  = 1'b0;
    bus.com_pol  = 1'b1;
    bus.lz_blank = 1'b0;
    bus.blink_en = 1'b0;
    modelReset();
    #2;
    checkOutput();
    checkOne("rst_seg_pad", bus.seg, 8'hFF);
    checkOne("rst_com_pad", 8'(bus.com), 8'h00);
    @(posedge clk);
    #1;
    checkOutput();
    rst = 1'b0;
    applyStimulus(1);
    checkOne("oe_after_release", 8'(bus.com_oe), 8'h03);

    $display("[TB] scan and load");
    bus.seg_pol = 1'b1;
    doLoad(8'h42, 2'b00);
    crossFrame();
    waitPhase(1);
    checkOne("d0_blank_slot", 8'(bus.com), 8'h00);
    waitPhase(6);
    checkOne("d0_seg_2", bus.seg, 8'h5B);
    checkOne("d0_com", 8'(bus.com), 8'h01);
    waitPhase(22);
    checkOne("d1_seg_4", bus.seg, 8'h66);
    fsCount = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      applyStimulus(1);
      if (bus.frame_start) fsCount++;
    end
    checkOne("fs_per_64", 8'(fsCount), 8'd2);

    $display("[TB] tear-free update");
    waitPhase(3);
    doLoad(8'h17, 2'b00);
    waitPhase(10);
    checkOne("no_tear_seg", bus.seg, 8'h5B);
    checkOne("pending_held", 8'(bus.pending), 8'h01);
    crossFrame();
    checkOne("pending_clear", 8'(bus.pending), 8'h00);
    waitPhase(6);
    checkOne("new_d0_seg", bus.seg, 8'h07);
    waitPhase(22);
    checkOne("new_d1_seg", bus.seg, 8'h06);

    $display("[TB] load on boundary");
    waitPhase(FRAME - 1);
    doLoad(8'h33, 2'b10);
    checkOne("boundary_no_pending", 8'(bus.pending), 8'h00);
    waitPhase(22);
    checkOne("boundary_d1_seg", bus.seg, 8'hCF);

    $display("[TB] leading zeros");
    bus.lz_blank = 1'b1;
    doLoad(8'h05, 2'b00);
    crossFrame();
    waitPhase(6);
    checkOne("lz_d0", bus.seg, 8'h6D);
    waitPhase(22);
    checkOne("lz_d1", bus.seg, 8'h00);
    doLoad(8'h00, 2'b00);
    crossFrame();
    waitPhase(6);
    checkOne("lz_zero_d0", bus.seg, 8'h3F);
    waitPhase(22);
    checkOne("lz_zero_d1", bus.seg, 8'h00);

    $display("[TB] special codes");
    doLoad(8'hFA, 2'b01);
    crossFrame();
    waitPhase(6);
    checkOne("code_a_dp", bus.seg, 8'hC0);
    waitPhase(22);
    checkOne("code_f", bus.seg, 8'h00);

    $display("[TB] polarity");
    bus.seg_pol = 1'b0;
    bus.com_pol = 1'b0;
    #1;
    checkOutput();
    bus.seg_pol = 1'b1;
    bus.com_pol = 1'b1;
    #1;
    checkOutput();

    $display("[TB] blink");
    bus.blink_en = 1'b1;
    litCount = 0;
    for (int i = 0; i < (1 << BL); i++) begin
      applyStimulus(1);
      if (bus.com != '0) litCount++;
    end
    checkOne("blink_lit_per_64", 8'(litCount), 8'd28);
    bus.blink_en = 1'b0;

    $display("[TB] mid-slot reset");
    waitPhase(20);
    doLoad(8'h99, 2'b11);
    applyStimulus(2);
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput();
    checkOne("rst_mid_com", 8'(bus.com), 8'h00);
    @(posedge clk);
    #1;
    checkOutput();
    rst = 1'b0;
    applyStimulus(40);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        bus.seg_pol = 1'($urandom);
        bus.com_pol = 1'($urandom);
        #1;
        checkOutput();
      end
      if ($urandom_range(0, 99) == 0) bus.lz_blank = 1'($urandom);
      if ($urandom_range(0, 149) == 0) bus.blink_en = 1'($urandom);
      if ($urandom_range(0, 11) == 0) doLoad(8'($urandom), 2'($urandom));
      else applyStimulus(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised, time-multiplexed 7-segment display driver for N common-cathode or common-anode digits.
- Sits between the dice/roll logic (BCD digits) and the uo_out/uio_out pads.
- Generalises the fixed two-digit display to NUM_DIGITS digits, adding runtime polarity select, tear-free double-buffered loads, anti-ghosting blanking, leading-zero suppression and blink.

Parameters:
NUM_DIGITS, 2, number of multiplexed digits (1..8)
SCAN_DIV, 1024, clocks per digit slot (>= BLANK_CYCLES+2)
BLANK_CYCLES, 16, clocks at slot start with all commons off (anti-ghost)
BLINK_LOG2, 22, blink period = 2^BLINK_LOG2 clocks, 50% duty

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
data_in  in  4*NUM_DIGITS  BCD digits; nibble 0 = least-significant digit
dp_in  in  NUM_DIGITS  decimal-point per digit
load  in  1  single-cycle strobe capturing data_in/dp_in
seg_pol  in  1  1 = segments active-high, 0 = active-low
com_pol  in  1  1 = commons active-high, 0 = active-low
lz_blank  in  1  enable leading-zero blanking
blink_en  in  1  enable blink
seg  out  8  segments {dp,g,f,e,d,c,b,a}
com  out  NUM_DIGITS  digit commons
com_oe  out  NUM_DIGITS  common output enables; all 1 after reset release
frame_start  out  1  one-cycle pulse when digit 0 slot begins
pending  out  1  load captured, not yet displayed

Behaviour:
- Internal state is registered and active-high. Pads are a combinational XOR: seg = seg_int ^ {8{~seg_pol}}, com = com_int ^ {N{~com_pol}}.
- Reset (async): slot_cnt=0, digit_idx=0, seg_int=0, com_int=0, com_oe=0, shadow=0, pending_reg=0, blink_cnt=0, frame_start=0. Pads are therefore dark for either polarity.
- com_oe goes all-1 on the first clock after rst deasserts.
- slot_cnt counts 0..SCAN_DIV-1 and wraps.
  - At wrap, digit_idx increments modulo NUM_DIGITS.
  - When digit_idx wraps to 0, frame_start pulses for exactly one cycle, registered and coincident with slot_cnt==0 of digit 0.
- Commons:
  - While slot_cnt < BLANK_CYCLES, com_int=0 and seg_int=0.
  - Otherwise com_int is one-hot at digit_idx and seg_int is the decode of shadow[digit_idx].
  - Outputs lag the counter by one register stage (latency 1 clock).
- Decode:
  - 0..9 → standard patterns: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - 10..14 → minus (0x40).
  - 15 → blank (0x00).
  - dp bit ORed from shadow dp.
- Leading-zero blanking, when lz_blank=1:
  - Scan from digit NUM_DIGITS-1 downward; each digit equal to 0 is blanked (segments and dp 0) until the first nonzero digit.
  - Digit 0 is never blanked.
- Blink: blink_cnt is free-running. When blink_en=1 and blink_cnt[BLINK_LOG2-1]=1, com_int=0.
- Double buffering:
  - load copies data_in/dp_in into the staging register and sets pending_reg.
  - At the last cycle of the last digit slot (frame boundary), if pending_reg=1, shadow ← staging and pending_reg clears.
  - Load while pending: staging is overwritten, last value wins.
  - Load on the boundary cycle itself: data_in goes directly to shadow, pending_reg stays 0.
  - The shadow never changes mid-frame, so no tearing.
- Polarity inputs may change at any time; the effect is immediate (combinational). No other state is affected.
- Reset mid-frame: all state returns to reset values immediately. Staged data is discarded.

Test Plan:
Settings for all scenarios: NUM_DIGITS=2, SCAN_DIV=16, BLANK_CYCLES=2, BLINK_LOG2=6.
- Reset/polarity: hold rst with seg_pol=0, com_pol=1 → seg=0xFF, com=2'b00, com_oe=0. Release → com_oe=2'b11 on the next clock.
- Scan/load: load 0x42, then wait one frame.
  - Digit 0 slot: cycles 0-1 com inactive; cycles 2-15 com_int=01 with seg=0x5B.
  - Digit 1 slot: seg=0x66.
  - frame_start is high once every 32 clocks.
- Tear-free: load 0x42, then load 0x17 in digit 0's slot → shadow stays 0x42 until the frame boundary, then displays 0x07/0x06. pending goes 1→0 at the boundary.
- Leading zeros: load 0x05 with lz_blank=1 → digit 1 seg=0x00, digit 0 seg=0x6D. Load 0x00 → digit 0 shows 0x3F.
- Special codes: load 0xFA with dp_in=2'b01 → digit 1 seg=0x00, digit 0 seg=0xC0.
- Blink and async reset: blink_en=1 → commons are dark for 32 of every 64 clocks. Assert rst mid-slot → com_int=0 in the same cycle; pending clears.
